// File: rtl/hist_sd_pkg.sv
// Shared definitions for the histogram SD save/load paths: FSM state
// encodings, slot/sector geometry and the byte-half selector.
package hist_sd_pkg;

    localparam int unsigned SECTOR_BYTES = 512;
    localparam int unsigned NUM_SECTORS  = 4;
    localparam int unsigned SLOT_SHIFT   = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        START = 2'd2,
        LOAD  = 2'd3
    } hist_sd_state_e;

    // Which byte of a 16-bit bin is expected next; bins are stored MS first.
    typedef enum logic {
        MS = 1'b0,
        LS = 1'b1
    } hist_sd_half_e;

endpackage

// File: rtl/sd_byte_edge.sv
// Rising-edge detector for the sd_controller byte strobes
// (sd_byte_available on the load path, sd_ready_for_next_byte on the save path).
module sd_byte_edge (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic last_q;
    logic last_d;

    // Previous-cycle copy of the level input.
    always_comb begin
        last_d = level;
    end

    // Register the level; cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end

    assign rise = level & ~last_q;

endmodule

// File: rtl/histogram_loader.sv
// Restores a saved 1024 x 16-bit histogram slot from SD card into the
// histogram BRAM write port. Slot N starts at byte 2048*N and spans four
// 512-byte sectors; each bin is stored MS byte first.
// Optional build macro HIST_LOAD_SUM_EN enables the hist_total accumulator.
module histogram_loader
    import hist_sd_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        slot,
    input  logic              sd_ready,
    input  logic              sd_byte_available,
    input  logic [7:0]        sd_dout,
    output logic              sd_rd,
    output logic [31:0]       sd_address,
    output logic [ADDR_W-1:0] waddr,
    output logic [15:0]       wdata,
    output logic              we,
    output logic              loading,
    output logic              done,
    output logic              err,
    output logic [31:0]       hist_total
);

    localparam int unsigned SEC_W = $clog2(NUM_SECTORS);

    hist_sd_state_e    state_q,      state_d;
    hist_sd_half_e     half_q,       half_d;
    logic              sd_rd_q,      sd_rd_d;
    logic [31:0]       sd_address_q, sd_address_d;
    logic [ADDR_W-1:0] waddr_q,      waddr_d;
    logic [15:0]       wdata_q,      wdata_d;
    logic              we_q,         we_d;
    logic              loading_q,    loading_d;
    logic              done_q,       done_d;
    logic              err_q,        err_d;
    logic [9:0]        byte_cnt_q,   byte_cnt_d;
    logic [SEC_W-1:0]  sector_q,     sector_d;
    logic [7:0]        hi_q,         hi_d;
    logic              byte_evt;

    sd_byte_edge u_byte_edge (
        .clk   (clk),
        .reset (reset),
        .level (sd_byte_available),
        .rise  (byte_evt)
    );

`ifdef HIST_LOAD_SUM_EN
    logic [31:0] total_q, total_d;
`endif

    // Next-state and output computation for the load sequencer.
    always_comb begin
        state_d      = state_q;
        half_d       = half_q;
        sd_rd_d      = sd_rd_q;
        sd_address_d = sd_address_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        we_d         = 1'b0;
        loading_d    = loading_q;
        done_d       = 1'b0;
        err_d        = err_q;
        byte_cnt_d   = byte_cnt_q;
        sector_d     = sector_q;
        hi_d         = hi_q;
`ifdef HIST_LOAD_SUM_EN
        total_d      = total_q;
        if (we_q) begin
            total_d = total_q + {16'd0, wdata_q};
        end
`endif

        // The write address advances on the cycle after each write, so the
        // final write at the top bin leaves waddr wrapped to zero.
        if (we_q) begin
            waddr_d = waddr_q + ADDR_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    sd_address_d = 32'(slot) << SLOT_SHIFT;
                    sector_d     = '0;
                    waddr_d      = '0;
                    byte_cnt_d   = '0;
                    half_d       = MS;
                    err_d        = 1'b0;
                    loading_d    = 1'b1;
                    state_d      = INIT;
`ifdef HIST_LOAD_SUM_EN
                    total_d      = '0;
`endif
                end else begin
                    loading_d = 1'b0;
                end
            end
            INIT: begin
                if (sd_ready) begin
                    sd_rd_d = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (!sd_ready) begin
                    sd_rd_d = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (byte_evt) begin
                    // Bytes past the sector length are dropped; the count
                    // saturates so the overrun is still flagged at sector end.
                    if (byte_cnt_q < 10'(SECTOR_BYTES)) begin
                        if (half_q == MS) begin
                            hi_d   = sd_dout;
                            half_d = LS;
                        end else begin
                            wdata_d = {hi_q, sd_dout};
                            we_d    = 1'b1;
                            half_d  = MS;
                        end
                    end
                    if (byte_cnt_q != '1) begin
                        byte_cnt_d = byte_cnt_q + 10'd1;
                    end
                end else if (sd_ready) begin
                    if (byte_cnt_q != 10'(SECTOR_BYTES)) begin
                        err_d     = 1'b1;
                        loading_d = 1'b0;
                        state_d   = IDLE;
                    end else if (sector_q == SEC_W'(NUM_SECTORS - 1)) begin
                        done_d    = 1'b1;
                        loading_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        sector_d     = sector_q + SEC_W'(1);
                        sd_address_d = sd_address_q + 32'(SECTOR_BYTES);
                        byte_cnt_d   = '0;
                        state_d      = INIT;
                    end
                end
            end
            default: begin
                sd_rd_d   = 1'b0;
                loading_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // Single register bank for the sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            half_q       <= MS;
            sd_rd_q      <= 1'b0;
            sd_address_q <= '0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            loading_q    <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            byte_cnt_q   <= '0;
            sector_q     <= '0;
            hi_q         <= '0;
        end else begin
            state_q      <= state_d;
            half_q       <= half_d;
            sd_rd_q      <= sd_rd_d;
            sd_address_q <= sd_address_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            loading_q    <= loading_d;
            done_q       <= done_d;
            err_q        <= err_d;
            byte_cnt_q   <= byte_cnt_d;
            sector_q     <= sector_d;
            hi_q         <= hi_d;
        end
    end

`ifdef HIST_LOAD_SUM_EN
    // Running sum of written bins; holds after completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            total_q <= '0;
        end else begin
            total_q <= total_d;
        end
    end

    assign hist_total = total_q;
`else
    assign hist_total = '0;
`endif

    assign sd_rd      = sd_rd_q;
    assign sd_address = sd_address_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign we         = we_q;
    assign loading    = loading_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
